// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope capture block.
// Holds the FSM encoding, frame geometry and the trigger comparator.
package scope_pkg;

   localparam int DEPTH_DEF   = 640;
   localparam int TIMEOUT_DEF = 2048;
   localparam int ADDR_W      = 10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TRIG,
      CAPTURE,
      DONE
   } state_t;

   // True when the sample pair crosses the level in the chosen direction.
   function automatic logic edge_hit(
      input logic       fall,
      input logic [7:0] prev,
      input logic [7:0] cur,
      input logic [7:0] lvl
   );
      if (fall)
         return (prev > lvl) && (cur <= lvl);
      else
         return (prev < lvl) && (cur >= lvl);
   endfunction

endpackage

// File: rtl/adc_trig_capture_if.sv
// Display read bus for the capture buffer.
// The display side drives the address and receives the sample.
interface adc_trig_capture_if;
   import scope_pkg::*;

   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;

   modport master (
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/capture_ram.sv
// Frame buffer: simple dual-port, synchronous write, registered read.
// Out-of-range read addresses return zero; contents survive reset.
module capture_ram
   import scope_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [7:0]        wd,
   input  logic [ADDR_W-1:0] ra,
   output logic [7:0]        rd
);

   logic [7:0] mem [DEPTH];

   // Write port; storage has no reset so a frame outlives rst.
   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   // Registered read port with zero for addresses past the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd <= 8'd0;
      else if (int'(ra) < DEPTH)
         rd <= mem[ra];
      else
         rd <= 8'd0;
   end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered ADC frame capture for a VGA scope display.
// Arm, wait for a level crossing (or timeout), then store one frame.
module adc_trig_capture
   import scope_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  adc_din,
   output logic        adc_clk,
   input  logic [15:0] div,
   input  logic [7:0]  trig_level,
   input  logic        trig_edge,
   input  logic        auto_mode,
   input  logic        arm,
   adc_trig_capture_if.slave rd,
   output logic        frame_ready,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_nx;
   logic [15:0]       div_q;
   logic [15:0]       scnt;
   logic [7:0]        level_q;
   logic              edge_q;
   logic              auto_q;
   logic [7:0]        prev;
   logic              prev_vld;
   logic [TW-1:0]     tcnt;
   logic [ADDR_W-1:0] waddr;

   logic              arm_ok;
   logic              strobe;
   logic              in_wait;
   logic              in_cap;
   logic              tout;
   logic              trig;
   logic              last;
   logic              we;
   logic [ADDR_W-1:0] wa;

   assign in_wait = (state == WAIT_TRIG);
   assign in_cap  = (state == CAPTURE);
   assign arm_ok  = arm && !busy;
   assign strobe  = busy && (scnt == div_q);
   assign tout    = auto_q && (tcnt == TW'(TIMEOUT - 1));
   assign trig    = in_wait && strobe &&
                    ((prev_vld &&
                      edge_hit(edge_q, prev, adc_din, level_q)) ||
                     tout);
   assign last    = in_cap && strobe &&
                    (waddr == ADDR_W'(DEPTH - 1));
   assign we      = trig || (in_cap && strobe);
   assign wa      = trig ? '0 : waddr;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (arm)  state_nx = WAIT_TRIG;
         WAIT_TRIG: if (trig) state_nx = CAPTURE;
         CAPTURE:   if (last) state_nx = DONE;
         DONE:      if (arm)  state_nx = WAIT_TRIG;
         default:             state_nx = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy = 1'b0;
      unique case (state)
         WAIT_TRIG: busy = 1'b1;
         CAPTURE:   busy = 1'b1;
         default:   busy = 1'b0;
      endcase
   end

   // Settings are frozen at arm so host writes cannot disturb a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         level_q <= '0;
         edge_q  <= 1'b0;
         auto_q  <= 1'b0;
      end else if (arm_ok) begin
         div_q   <= div;
         level_q <= trig_level;
         edge_q  <= trig_edge;
         auto_q  <= auto_mode;
      end
   end

   // Sample-period divider and the registered conversion clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt    <= '0;
         adc_clk <= 1'b0;
      end else begin
         adc_clk <= strobe;
         if (arm_ok)
            scnt <= '0;
         else if (busy)
            scnt <= strobe ? '0 : scnt + 16'd1;
      end
   end

   // Previous sample and saturating timeout count while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev     <= '0;
         prev_vld <= 1'b0;
         tcnt     <= '0;
      end else if (arm_ok) begin
         prev_vld <= 1'b0;
         tcnt     <= '0;
      end else if (in_wait && strobe) begin
         prev     <= adc_din;
         prev_vld <= 1'b1;
         if (tcnt != TW'(TIMEOUT))
            tcnt <= tcnt + 1'b1;
      end
   end

   // Write pointer and frame-complete flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr       <= '0;
         frame_ready <= 1'b0;
      end else begin
         if (trig)
            waddr <= ADDR_W'(1);
         else if (in_cap && strobe)
            waddr <= waddr + 1'b1;
         if (arm_ok)
            frame_ready <= 1'b0;
         else if (last)
            frame_ready <= 1'b1;
      end
   end

   capture_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk (clk),
      .rst (rst),
      .we  (we),
      .wa  (wa),
      .wd  (adc_din),
      .ra  (rd.rd_addr),
      .rd  (rd.rd_data)
   );

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture.
// Each task drives one scenario and checks hand-derived values.
module tb_adc_trig_capture;

   logic        clk;
   logic        rst;
   logic [7:0]  adc_din;
   logic        adc_clk;
   logic [15:0] div;
   logic [7:0]  trig_level;
   logic        trig_edge;
   logic        auto_mode;
   logic        arm;
   logic        frame_ready;
   logic        busy;

   int vectors;
   int miscompares;

   adc_trig_capture_if bus ();

   adc_trig_capture dut (
      .clk         (clk),
      .rst         (rst),
      .adc_din     (adc_din),
      .adc_clk     (adc_clk),
      .div         (div),
      .trig_level  (trig_level),
      .trig_edge   (trig_edge),
      .auto_mode   (auto_mode),
      .arm         (arm),
      .rd          (bus.slave),
      .frame_ready (frame_ready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_at(input int a, output logic [7:0] d);
      bus.rd_addr = 10'(a);
      tick();
      d = bus.rd_data;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      tick();
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if (busy !== 1'b0 || frame_ready !== 1'b0 ||
          adc_clk !== 1'b0 || bus.rd_data !== 8'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b fr=%b adc_clk=%b rd=%h want 0 0 0 00",
                  busy, frame_ready, adc_clk, bus.rd_data);
      end
   endtask

   task automatic test_rising();
      int first;
      logic [7:0] d;
      div = 16'd0; trig_level = 8'd128; trig_edge = 1'b0; auto_mode = 1'b0;
      do_arm();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rise_busy: got %b want 1", busy);
      end
      first = -1;
      for (int i = 0; i < 1200 && first < 0; i++) begin
         adc_din = 8'(100 + i);
         tick();
         if (frame_ready) first = i;
      end
      vectors++;
      if (first !== 667) begin
         miscompares++;
         $display("FAIL rise_frame_time: got %0d want 667", first);
      end
      read_at(0, d);
      vectors++;
      if (d !== 8'd128) begin miscompares++; $display("FAIL rise_rd0: got %h want 80", d); end
      read_at(1, d);
      vectors++;
      if (d !== 8'd129) begin miscompares++; $display("FAIL rise_rd1: got %h want 81", d); end
      read_at(127, d);
      vectors++;
      if (d !== 8'd255) begin miscompares++; $display("FAIL rise_rd127: got %h want ff", d); end
      read_at(128, d);
      vectors++;
      if (d !== 8'd0) begin miscompares++; $display("FAIL rise_rd128: got %h want 00", d); end
      read_at(639, d);
      vectors++;
      if (d !== 8'd255) begin miscompares++; $display("FAIL rise_rd639: got %h want ff", d); end
      read_at(640, d);
      vectors++;
      if (d !== 8'd0) begin miscompares++; $display("FAIL rd_oob640: got %h want 00", d); end
      read_at(1023, d);
      vectors++;
      if (d !== 8'd0) begin miscompares++; $display("FAIL rd_oob1023: got %h want 00", d); end
   endtask

   task automatic test_falling();
      int first;
      logic [7:0] d;
      div = 16'd0; trig_level = 8'd64; trig_edge = 1'b1; auto_mode = 1'b0;
      do_arm();
      first = -1;
      for (int i = 0; i < 1500 && first < 0; i++) begin
         adc_din = 8'(255 - i);
         tick();
         if (frame_ready) first = i;
      end
      vectors++;
      if (first !== 830) begin
         miscompares++;
         $display("FAIL fall_frame_time: got %0d want 830", first);
      end
      read_at(0, d);
      vectors++;
      if (d !== 8'd64) begin miscompares++; $display("FAIL fall_rd0: got %h want 40", d); end
      read_at(1, d);
      vectors++;
      if (d !== 8'd63) begin miscompares++; $display("FAIL fall_rd1: got %h want 3f", d); end
      read_at(65, d);
      vectors++;
      if (d !== 8'd255) begin miscompares++; $display("FAIL fall_rd65: got %h want ff", d); end
   endtask

   task automatic test_auto();
      int first;
      int bad;
      logic [7:0] d;
      div = 16'd0; trig_level = 8'h80; trig_edge = 1'b0; auto_mode = 1'b1;
      adc_din = 8'h55;
      do_arm();
      first = -1;
      for (int i = 0; i < 4000 && first < 0; i++) begin
         tick();
         if (frame_ready) first = i;
      end
      vectors++;
      if (first !== 2686) begin
         miscompares++;
         $display("FAIL auto_frame_time: got %0d want 2686", first);
      end
      bad = 0;
      for (int a = 0; a < 640; a++) begin
         read_at(a, d);
         if (d !== 8'h55) begin
            bad++;
            if (bad < 4) $display("FAIL auto_rd[%0d]: got %h want 55", a, d);
         end
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL auto_fill: %0d entries wrong, want 0", bad);
      end
   endtask

   task automatic test_auto_off();
      int bad;
      auto_mode = 1'b0;
      adc_din = 8'h55;
      do_arm();
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (busy !== 1'b1 || frame_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL auto_off_wait: %0d bad cycles, want 0", bad);
      end
      pulse_reset();
   endtask

   task automatic test_divider();
      int first;
      int bad;
      logic [7:0] d;
      div = 16'd3; trig_level = 8'd128; trig_edge = 1'b0; auto_mode = 1'b0;
      do_arm();
      first = -1;
      bad = 0;
      for (int i = 0; i < 4000 && first < 0; i++) begin
         adc_din = (i < 8) ? 8'd0 : 8'd200;
         arm = (i == 100);
         tick();
         if (i < 32 && adc_clk !== ((i % 4) == 3)) bad++;
         if (frame_ready) first = i;
      end
      arm = 1'b0;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL div_adc_clk: %0d bad cycles, want 0", bad);
      end
      vectors++;
      if (first !== 2567) begin
         miscompares++;
         $display("FAIL div_frame_time: got %0d want 2567", first);
      end
      read_at(0, d);
      vectors++;
      if (d !== 8'd200) begin miscompares++; $display("FAIL div_rd0: got %h want c8", d); end
      read_at(639, d);
      vectors++;
      if (d !== 8'd200) begin miscompares++; $display("FAIL div_rd639: got %h want c8", d); end
      do_arm();
      vectors++;
      if (frame_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rearm_done: fr=%b busy=%b want 0 1", frame_ready, busy);
      end
      pulse_reset();
   endtask

   task automatic test_reset_mid();
      int first;
      logic [7:0] d;
      div = 16'd0; trig_level = 8'd128; trig_edge = 1'b0; auto_mode = 1'b0;
      bus.rd_addr = 10'd5;
      do_arm();
      for (int i = 0; i < 300; i++) begin
         adc_din = 8'(100 + i);
         tick();
      end
      vectors++;
      if (busy !== 1'b1 || frame_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_capture: busy=%b fr=%b want 1 0", busy, frame_ready);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || frame_ready !== 1'b0 ||
          adc_clk !== 1'b0 || bus.rd_data !== 8'd0) begin
         miscompares++;
         $display("FAIL mid_reset: busy=%b fr=%b adc_clk=%b rd=%h want 0 0 0 00",
                  busy, frame_ready, adc_clk, bus.rd_data);
      end
      #2;
      rst = 1'b0;
      tick();
      do_arm();
      first = -1;
      for (int i = 0; i < 1200 && first < 0; i++) begin
         adc_din = 8'(100 + i);
         tick();
         if (frame_ready) first = i;
      end
      vectors++;
      if (first !== 667) begin
         miscompares++;
         $display("FAIL post_reset_frame: got %0d want 667", first);
      end
      read_at(0, d);
      vectors++;
      if (d !== 8'd128) begin miscompares++; $display("FAIL post_reset_rd0: got %h want 80", d); end
      read_at(200, d);
      vectors++;
      if (d !== 8'd72) begin miscompares++; $display("FAIL post_reset_rd200: got %h want 48", d); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      adc_din = 8'd0;
      div = 16'd0;
      trig_level = 8'd0;
      trig_edge = 1'b0;
      auto_mode = 1'b0;
      arm = 1'b0;
      bus.rd_addr = 10'd0;
      #2;
      test_reset();
      #6;
      rst = 1'b0;
      tick();
      test_rising();
      test_falling();
      test_auto();
      test_auto_off();
      test_divider();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adc_trig_capture.md
ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 640, samples per captured frame (one per VGA column).
REQ-002 SHALL have parameter TIMEOUT, default 2048, sample strobes before auto-mode forces a trigger.
REQ-003 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port adc_din, input, 8, unsigned ADC sample (looped from DAC output).
REQ-006 SHALL have port adc_clk, output, 1, ADC conversion clock, one clk-wide high pulse per sample period.
REQ-007 SHALL have port div, input, 16, sample period = div+1 clk cycles.
REQ-008 SHALL have port trig_level, input, 8, trigger threshold.
REQ-009 SHALL have port trig_edge, input, 1, 0 = rising, 1 = falling.
REQ-010 SHALL have port auto_mode, input, 1, enables forced trigger on timeout.
REQ-011 SHALL have port arm, input, 1, single-cycle pulse starting an acquisition.
REQ-012 SHALL have port rd_addr, input, 10, display read address.
REQ-013 SHALL have port rd_data, output, 8, sample at rd_addr.
REQ-014 SHALL have port frame_ready, output, 1, complete frame held in buffer.
REQ-015 SHALL have port busy, output, 1, high in WAIT_TRIG or CAPTURE.

Function
REQ-016 SHALL implement states IDLE, WAIT_TRIG, CAPTURE, DONE.
REQ-017 SHALL, on arm in IDLE or DONE: latch div, trig_level, trig_edge and auto_mode; clear the strobe counter, timeout counter and frame_ready; enter WAIT_TRIG next cycle.
REQ-018 SHALL ignore arm while busy.
REQ-019 SHALL generate the sample strobe when the strobe counter equals the latched div, then wrap the counter to 0; div=0 strobes every clk.
REQ-020 SHALL drive adc_clk as the strobe registered once (high exactly one clk per sample period).
REQ-021 SHALL, in WAIT_TRIG, register each strobed sample as prev; the first strobe after arm only loads prev.
REQ-022 SHALL detect a rising trigger when prev < level and cur >= level, and a falling trigger when prev > level and cur <= level.
REQ-023 SHALL force a trigger on the strobe that reaches TIMEOUT strobes in WAIT_TRIG when auto_mode is latched high.
REQ-024 SHALL write the triggering sample (cur) to address 0 and enter CAPTURE; each later strobe writes to the next address.
REQ-025 SHALL enter DONE after writing address DEPTH-1, setting frame_ready in that same transition.
REQ-026 SHALL provide rd_data with 1 clk latency from rd_addr; rd_addr >= DEPTH returns 0; reads are allowed in any state.
REQ-027 SHALL keep buffer contents unchanged in IDLE, WAIT_TRIG and DONE.

Reset
REQ-028 SHALL reset state to IDLE; adc_clk, frame_ready and busy to 0; all counters and latched settings to 0; rd_data to 0.
REQ-029 SHALL, when reset asserts mid-capture, abandon the frame; buffer RAM is not cleared.

Structure
REQ-030 SHALL take state encoding, DEPTH and TIMEOUT defaults from a shared package (scope_pkg).
REQ-031 SHALL place storage in one sub-module capture_ram: simple dual-port, DEPTH x 8, synchronous write and registered read.

Verification
REQ-032 Rising trigger: ramp 0..255 wrapping, one step per clk, div=0, level=128, edge=0, arm -> rd_data[0]=128, [1]=129, [127]=255, [128]=0; frame_ready rises 640 strobes after the trigger.
REQ-033 Falling trigger: descending ramp 255..0, level=64, edge=1 -> rd_data[0]=64, [1]=63.
REQ-034 Auto mode: constant input 0x55, auto_mode=1, arm -> trigger forced at strobe 2048; all 640 entries = 0x55; with auto_mode=0, busy stays high and frame_ready stays 0 indefinitely.
REQ-035 Divider: div=3 -> adc_clk pulses every 4 clk; a full frame takes 2560 clk after the trigger.
REQ-036 Arm during CAPTURE ignored -> frame completes unchanged; re-arm in DONE drops frame_ready the next cycle.
REQ-037 Reset asserted mid-CAPTURE -> IDLE, busy=0, frame_ready=0 immediately; a subsequent arm completes a normal frame.
